// File: rtl/cvxif_result_arbiter_if.sv
// Result-channel bundle between NrSrc functional units, the CPU commit port
// and the arbiter that shares the single CV-X-IF result channel.
//   slave  : arbiter side. It takes source requests, commit info and
//            result_ready_i. It drives src_ready_o, result_*_o and
//            drop_count_o.
//   master : environment side. This is the functional units plus the CPU.
interface cvxif_result_arbiter_if #(
  parameter int unsigned NrSrc       = 2,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned HartidWidth = 1,
  parameter int unsigned DataWidth   = 64
);
  logic [NrSrc-1:0]             src_valid_i;
  logic [NrSrc-1:0]             src_ready_o;
  logic [NrSrc*HartidWidth-1:0] src_hartid_i;
  logic [NrSrc*IdWidth-1:0]     src_id_i;
  logic [NrSrc*DataWidth-1:0]   src_data_i;
  logic [NrSrc*5-1:0]           src_rd_i;
  logic [NrSrc-1:0]             src_we_i;

  logic                         commit_valid_i;
  logic [HartidWidth-1:0]       commit_hartid_i;
  logic [IdWidth-1:0]           commit_id_i;
  logic                         commit_kill_i;

  logic                         result_valid_o;
  logic                         result_ready_i;
  logic [HartidWidth-1:0]       result_hartid_o;
  logic [IdWidth-1:0]           result_id_o;
  logic [DataWidth-1:0]         result_data_o;
  logic [4:0]                   result_rd_o;
  logic                         result_we_o;
  logic [15:0]                  drop_count_o;

  modport slave (
    input  src_valid_i, src_hartid_i, src_id_i, src_data_i, src_rd_i, src_we_i,
    input  commit_valid_i, commit_hartid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output src_ready_o,
    output result_valid_o, result_hartid_o, result_id_o, result_data_o,
    output result_rd_o, result_we_o, drop_count_o
  );

  modport master (
    output src_valid_i, src_hartid_i, src_id_i, src_data_i, src_rd_i, src_we_i,
    output commit_valid_i, commit_hartid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  src_ready_o,
    input  result_valid_o, result_hartid_o, result_id_o, result_data_o,
    input  result_rd_o, result_we_o, drop_count_o
  );
endinterface

// File: rtl/cvxif_result_arbiter.sv
// Round-robin arbiter for the CV-X-IF result channel.
// It picks one of NrSrc functional-unit results and holds it in a single
// output register until the CPU takes it with result_ready_i. Results whose
// instruction the CPU kills on the commit port are dropped and counted in a
// saturating 16-bit counter.
// Ports:
//   clk_i : clock.
//   rst_i : synchronous reset, active-high.
//   bus   : cvxif_result_arbiter_if.slave. It carries the per-source request
//           fields (packed, source 0 in the LSBs), src_ready_o grants, the
//           commit/kill port, the result_* channel and drop_count_o.
module cvxif_result_arbiter #(
  parameter int unsigned NrSrc       = 2,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned HartidWidth = 1,
  parameter int unsigned DataWidth   = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cvxif_result_arbiter_if.slave  bus
);

  localparam int unsigned PtrWidth = (NrSrc > 1) ? $clog2(NrSrc) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PtrWidth-1:0]    ptr_q, ptr_d;
  logic [HartidWidth-1:0] hartid_q, hartid_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [4:0]             rd_q, rd_d;
  logic                   we_q, we_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;

  logic                   grant_valid;
  logic [PtrWidth-1:0]    grant_idx;
  logic [HartidWidth-1:0] gnt_hartid;
  logic [IdWidth-1:0]     gnt_id;
  logic [DataWidth-1:0]   gnt_data;
  logic [4:0]             gnt_rd;
  logic                   gnt_we;

  logic                   kill_strobe;
  logic                   held_match;
  logic                   held_drop;
  logic                   accept;
  logic                   grant;
  logic                   in_match;
  logic                   in_drop;
  logic                   load;
  logic [1:0]             drop_inc;
  logic [16:0]            drop_sum;
  logic [NrSrc-1:0]       src_ready;

  // Round-robin scan that starts at ptr_q and wraps modulo NrSrc.
  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned off = 0; off < NrSrc; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NrSrc) idx = idx - NrSrc;
      if (!grant_valid && bus.src_valid_i[idx[PtrWidth-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[PtrWidth-1:0];
      end
    end
  end

  always_comb begin
    gnt_hartid = bus.src_hartid_i[int'(grant_idx)*HartidWidth +: HartidWidth];
    gnt_id     = bus.src_id_i[int'(grant_idx)*IdWidth +: IdWidth];
    gnt_data   = bus.src_data_i[int'(grant_idx)*DataWidth +: DataWidth];
    gnt_rd     = bus.src_rd_i[int'(grant_idx)*5 +: 5];
    gnt_we     = bus.src_we_i[grant_idx];
  end

  assign kill_strobe = bus.commit_valid_i & bus.commit_kill_i;
  assign held_match  = (state_q == HOLD) & kill_strobe &
                       (bus.commit_id_i == id_q) & (bus.commit_hartid_i == hartid_q);
  // A transfer in the same cycle takes priority over a kill of the held entry.
  assign held_drop   = held_match & ~bus.result_ready_i;

  // A kill of the held entry frees the register in the same cycle. This lets
  // a new grant load alongside the drop, so held and incoming kills can
  // coincide.
  assign accept      = (state_q == EMPTY) | bus.result_ready_i | held_match;
  assign grant       = accept & grant_valid;
  assign in_match    = kill_strobe & (bus.commit_id_i == gnt_id) &
                       (bus.commit_hartid_i == gnt_hartid);
  assign in_drop     = grant & in_match;
  assign load        = grant & ~in_match;

  always_comb begin
    src_ready = '0;
    if (!rst_i && grant) src_ready[grant_idx] = 1'b1;
  end
  assign bus.src_ready_o = src_ready;

  assign drop_inc = {1'b0, held_drop} + {1'b0, in_drop};
  assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_inc};

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hartid_d   = hartid_q;
    id_d       = id_q;
    data_d     = data_q;
    rd_d       = rd_q;
    we_d       = we_q;
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    if (grant) begin
      if (int'(grant_idx) == NrSrc - 1) ptr_d = '0;
      else                              ptr_d = grant_idx + PtrWidth'(1);
    end

    if (load) begin
      state_d  = HOLD;
      hartid_d = gnt_hartid;
      id_d     = gnt_id;
      data_d   = gnt_data;
      rd_d     = gnt_rd;
      we_d     = gnt_we;
    end else begin
      unique case (state_q)
        HOLD:    state_d = (bus.result_ready_i || held_match) ? EMPTY : HOLD;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      hartid_q   <= '0;
      id_q       <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hartid_q   <= hartid_d;
      id_q       <= id_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.result_valid_o  = (state_q == HOLD);
  assign bus.result_hartid_o = hartid_q;
  assign bus.result_id_o     = id_q;
  assign bus.result_data_o   = data_q;
  assign bus.result_rd_o     = rd_q;
  assign bus.result_we_o     = we_q;
  assign bus.drop_count_o    = drop_cnt_q;

endmodule

// File: tb/tb_cvxif_result_arbiter.sv
module tb_cvxif_result_arbiter;
  localparam int unsigned NrSrc = 2;
  localparam int unsigned IdW   = 4;
  localparam int unsigned HidW  = 1;
  localparam int unsigned DW    = 64;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cvxif_result_arbiter_if #(.NrSrc(NrSrc), .IdWidth(IdW), .HartidWidth(HidW), .DataWidth(DW)) bus ();

  cvxif_result_arbiter #(.NrSrc(NrSrc), .IdWidth(IdW), .HartidWidth(HidW), .DataWidth(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and registered outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [IdW-1:0] id,
                         input logic [DW-1:0] data, input logic [4:0] rd, input logic we);
    bus.src_valid_i[s]              = v;
    bus.src_hartid_i[s*HidW +: HidW] = '0;
    bus.src_id_i[s*IdW +: IdW]      = id;
    bus.src_data_i[s*DW +: DW]      = data;
    bus.src_rd_i[s*5 +: 5]          = rd;
    bus.src_we_i[s]                 = we;
  endtask

  task automatic set_commit(input logic v, input logic kill, input logic [IdW-1:0] id);
    bus.commit_valid_i  = v;
    bus.commit_kill_i   = kill;
    bus.commit_id_i     = id;
    bus.commit_hartid_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_src(0, 1'b1, 4'd1, 64'h11, 5'd1, 1'b1);
    set_src(1, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    set_commit(1'b0, 1'b0, 4'd0);
    bus.result_ready_i = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.src_ready_o !== 2'b00) begin n_err++; $display("FAIL reset_src_ready: got %b expected 00", bus.src_ready_o); end
    n_cmp++; if (bus.result_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid_o); end
    n_cmp++; if (bus.result_id_o !== 4'd0) begin n_err++; $display("FAIL reset_id: got %h expected 0", bus.result_id_o); end
    n_cmp++; if (bus.result_data_o !== 64'd0) begin n_err++; $display("FAIL reset_data: got %h expected 0", bus.result_data_o); end
    n_cmp++; if (bus.drop_count_o !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %h expected 0", bus.drop_count_o); end
    set_src(0, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0]     exp_rdy;
    logic [IdW-1:0] exp_id;
    set_src(0, 1'b1, 4'd1, 64'hA0, 5'd1, 1'b1);
    set_src(1, 1'b1, 4'd2, 64'hB1, 5'd2, 1'b1);
    bus.result_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_id  = (i % 2 == 0) ? 4'd1 : 4'd2;
      #1;
      n_cmp++; if (bus.src_ready_o !== exp_rdy) begin n_err++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, bus.src_ready_o, exp_rdy); end
      tick();
      n_cmp++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== exp_id) begin n_err++; $display("FAIL rr_result[%0d]: got v=%b id=%h expected v=1 id=%h", i, bus.result_valid_o, bus.result_id_o, exp_id); end
    end
    set_src(0, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    set_src(1, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    tick();
    n_cmp++; if (bus.result_valid_o !== 1'b0) begin n_err++; $display("FAIL rr_drain: got %b expected 0", bus.result_valid_o); end
  endtask

  task automatic test_hold();
    set_src(1, 1'b1, 4'd3, 64'hDEAD_BEEF, 5'd5, 1'b1);
    bus.result_ready_i = 1'b0;
    #1;
    n_cmp++; if (bus.src_ready_o !== 2'b10) begin n_err++; $display("FAIL hold_grant: got %b expected 10", bus.src_ready_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd3 || bus.result_data_o !== 64'hDEAD_BEEF ||
          bus.result_rd_o !== 5'd5 || bus.result_we_o !== 1'b1 || bus.src_ready_o !== 2'b00) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: got v=%b id=%h data=%h rd=%0d we=%b rdy=%b expected v=1 id=3 data=deadbeef rd=5 we=1 rdy=00",
                 i, bus.result_valid_o, bus.result_id_o, bus.result_data_o, bus.result_rd_o, bus.result_we_o, bus.src_ready_o);
      end
      tick();
    end
    set_src(1, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    bus.result_ready_i = 1'b1;
    tick();
    n_cmp++; if (bus.result_valid_o !== 1'b0) begin n_err++; $display("FAIL hold_release: got %b expected 0", bus.result_valid_o); end
  endtask

  task automatic test_kill_held();
    bus.result_ready_i = 1'b0;
    set_src(0, 1'b1, 4'd2, 64'h22, 5'd2, 1'b1);
    tick();
    set_src(0, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    set_commit(1'b1, 1'b0, 4'd2);
    tick();
    n_cmp++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd2 || bus.drop_count_o !== 16'd0) begin n_err++; $display("FAIL nonkill_commit: got v=%b id=%h drop=%0d expected v=1 id=2 drop=0", bus.result_valid_o, bus.result_id_o, bus.drop_count_o); end
    set_commit(1'b1, 1'b1, 4'd2);
    tick();
    set_commit(1'b0, 1'b0, 4'd0);
    n_cmp++; if (bus.result_valid_o !== 1'b0 || bus.drop_count_o !== 16'd1) begin n_err++; $display("FAIL kill_held: got v=%b drop=%0d expected v=0 drop=1", bus.result_valid_o, bus.drop_count_o); end
    set_src(0, 1'b1, 4'd2, 64'h22, 5'd2, 1'b1);
    #1;
    n_cmp++; if (bus.src_ready_o !== 2'b01) begin n_err++; $display("FAIL kill_held_regrant: got %b expected 01", bus.src_ready_o); end
    tick();
    set_src(0, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    set_commit(1'b1, 1'b1, 4'd2);
    bus.result_ready_i = 1'b1;
    #1;
    n_cmp++; if (bus.result_valid_o !== 1'b1) begin n_err++; $display("FAIL kill_vs_xfer_valid: got %b expected 1", bus.result_valid_o); end
    tick();
    set_commit(1'b0, 1'b0, 4'd0);
    n_cmp++; if (bus.result_valid_o !== 1'b0 || bus.drop_count_o !== 16'd1) begin n_err++; $display("FAIL kill_vs_xfer: got v=%b drop=%0d expected v=0 drop=1", bus.result_valid_o, bus.drop_count_o); end
  endtask

  task automatic test_kill_incoming();
    // Pointer is 1 here; source 1 idle so source 0 wins after wrapping.
    bus.result_ready_i = 1'b0;
    set_src(0, 1'b1, 4'd7, 64'h77, 5'd7, 1'b1);
    set_commit(1'b1, 1'b1, 4'd7);
    #1;
    n_cmp++; if (bus.src_ready_o !== 2'b01) begin n_err++; $display("FAIL kill_in_handshake: got %b expected 01", bus.src_ready_o); end
    tick();
    set_commit(1'b0, 1'b0, 4'd0);
    n_cmp++; if (bus.result_valid_o !== 1'b0 || bus.drop_count_o !== 16'd2) begin n_err++; $display("FAIL kill_in: got v=%b drop=%0d expected v=0 drop=2", bus.result_valid_o, bus.drop_count_o); end
    set_src(0, 1'b1, 4'd4, 64'h44, 5'd4, 1'b1);
    set_src(1, 1'b1, 4'd5, 64'h55, 5'd5, 1'b1);
    bus.result_ready_i = 1'b1;
    #1;
    n_cmp++; if (bus.src_ready_o !== 2'b10) begin n_err++; $display("FAIL kill_in_ptr: got %b expected 10", bus.src_ready_o); end
    tick();
    n_cmp++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd5) begin n_err++; $display("FAIL kill_in_next: got v=%b id=%h expected v=1 id=5", bus.result_valid_o, bus.result_id_o); end
    set_src(0, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    set_src(1, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_double_kill();
    bus.result_ready_i = 1'b0;
    set_src(0, 1'b1, 4'd6, 64'h66, 5'd6, 1'b1);
    tick();
    set_src(0, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    set_src(1, 1'b1, 4'd6, 64'h66, 5'd6, 1'b1);
    set_commit(1'b1, 1'b1, 4'd6);
    #1;
    n_cmp++; if (bus.src_ready_o !== 2'b10) begin n_err++; $display("FAIL dbl_kill_grant: got %b expected 10", bus.src_ready_o); end
    tick();
    set_commit(1'b0, 1'b0, 4'd0);
    set_src(1, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    n_cmp++; if (bus.result_valid_o !== 1'b0 || bus.drop_count_o !== 16'd4) begin n_err++; $display("FAIL dbl_kill: got v=%b drop=%0d expected v=0 drop=4", bus.result_valid_o, bus.drop_count_o); end
    set_src(0, 1'b1, 4'd8, 64'h88, 5'd8, 1'b1);
    tick();
    set_src(0, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    set_src(1, 1'b1, 4'd9, 64'h99, 5'd9, 1'b0);
    set_commit(1'b1, 1'b1, 4'd8);
    tick();
    set_commit(1'b0, 1'b0, 4'd0);
    set_src(1, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    n_cmp++;
    if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd9 || bus.result_data_o !== 64'h99 || bus.result_we_o !== 1'b0 || bus.drop_count_o !== 16'd5) begin
      n_err++;
      $display("FAIL kill_and_load: got v=%b id=%h data=%h we=%b drop=%0d expected v=1 id=9 data=99 we=0 drop=5",
               bus.result_valid_o, bus.result_id_o, bus.result_data_o, bus.result_we_o, bus.drop_count_o);
    end
    bus.result_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    bus.result_ready_i = 1'b0;
    set_src(0, 1'b1, 4'd1, 64'h10, 5'd1, 1'b1);
    set_src(1, 1'b1, 4'd2, 64'h20, 5'd2, 1'b1);
    tick();
    rst = 1'b1;
    bus.result_ready_i = 1'b1;
    #1;
    n_cmp++; if (bus.src_ready_o !== 2'b00) begin n_err++; $display("FAIL rst_gate: got %b expected 00", bus.src_ready_o); end
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.result_valid_o !== 1'b0 || bus.drop_count_o !== 16'd0) begin n_err++; $display("FAIL rst_mid_hold: got v=%b drop=%0d expected v=0 drop=0", bus.result_valid_o, bus.drop_count_o); end
    #1;
    n_cmp++; if (bus.src_ready_o !== 2'b01) begin n_err++; $display("FAIL rst_ptr: got %b expected 01", bus.src_ready_o); end
    tick();
    n_cmp++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd1) begin n_err++; $display("FAIL rst_first: got v=%b id=%h expected v=1 id=1", bus.result_valid_o, bus.result_id_o); end
    set_src(0, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    set_src(1, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_saturation();
    set_src(0, 1'b1, 4'd7, 64'h77, 5'd7, 1'b1);
    set_commit(1'b1, 1'b1, 4'd7);
    for (int i = 0; i < 65534; i++) tick();
    n_cmp++; if (bus.drop_count_o !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre: got %h expected fffe", bus.drop_count_o); end
    tick();
    n_cmp++; if (bus.drop_count_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_max: got %h expected ffff", bus.drop_count_o); end
    tick();
    tick();
    n_cmp++; if (bus.drop_count_o !== 16'hFFFF || bus.result_valid_o !== 1'b0) begin n_err++; $display("FAIL sat_hold: got drop=%h v=%b expected ffff v=0", bus.drop_count_o, bus.result_valid_o); end
    set_commit(1'b0, 1'b0, 4'd0);
    set_src(0, 1'b0, 4'd0, 64'h0, 5'd0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.src_valid_i  = '0;
    bus.src_hartid_i = '0;
    bus.src_id_i     = '0;
    bus.src_data_i   = '0;
    bus.src_rd_i     = '0;
    bus.src_we_i     = '0;
    bus.result_ready_i = 1'b0;
    set_commit(1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    test_reset();
    test_round_robin();
    test_hold();
    test_kill_held();
    test_kill_incoming();
    test_double_kill();
    test_reset_mid_hold();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
